// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time into a four-bit ALU: drive operands, let them settle,
// capture the result, and hold it on a valid/ready response. Optional accumulator: ALU_SEQ_ACCUM_EN.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_rot,
    input  logic       cmd_acc,

    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_s,
    output logic [1:0] alu_srot,
    input  logic [3:0] alu_y,
    input  logic       alu_y2,
    input  logic       alu_cout,
    input  logic       alu_bout,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_y,
    output logic [2:0] rsp_flags,
    output logic [2:0] rsp_op,
    output logic [3:0] rsp_tag,

    output logic       busy
);

    // Zero behaves as one; anything past the 4-bit counter range saturates.
    localparam int unsigned SettleEff  = (SETTLE_CYCLES == 0) ? 1 :
                                         (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
    localparam logic [3:0]  SettleLoad = 4'(SettleEff);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [3:0] op_a;

`ifdef ALU_SEQ_ACCUM_EN
    logic [3:0] acc_q;

    assign op_a = cmd_acc ? acc_q : cmd_a;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (state_q == StCapture) begin
            acc_q <= alu_y;
        end
    end
`else
    logic unused_cmd_acc;

    assign op_a           = cmd_a;
    assign unused_cmd_acc = cmd_acc;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            alu_srot  <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_flags <= '0;
            rsp_op    <= '0;
            rsp_tag   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_a     <= op_a;
                        alu_b     <= cmd_b;
                        alu_s     <= cmd_op;
                        alu_srot  <= cmd_rot;
                        cnt_q     <= SettleLoad;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= StIssue;
                    end else begin
                        // Covers the first cycle after reset release.
                        cmd_ready <= 1'b1;
                    end
                end
                StIssue: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    rsp_y     <= alu_y;
                    rsp_flags <= {alu_y2, alu_cout, alu_bout};
                    rsp_op    <= alu_s;
                    rsp_valid <= 1'b1;
                    state_q   <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_tag   <= rsp_tag + 4'd1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: cycles that ALU-facing outputs are held stable before results are captured; legal range 1..15, and 0 is treated as 1.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports cmd_valid input 1, cmd_ready output 1: command handshake.
REQ-005 SHALL have ports cmd_a input 4, cmd_b input 4, cmd_op input 3, cmd_rot input 2, cmd_acc input 1: command fields.
REQ-006 SHALL have ports alu_a output 4, alu_b output 4, alu_s output 3, alu_srot output 2: registered drive to the four-bit ALU operand and select inputs.
REQ-007 SHALL have ports alu_y input 4, alu_y2 input 1, alu_cout input 1, alu_bout input 1: ALU results.
REQ-008 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-009 SHALL have ports rsp_y output 4, rsp_flags output 3 ({y2,cout,bout}), rsp_op output 3 (echo of op), rsp_tag output 4 (transaction number).
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP.
REQ-012 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-013 On acceptance, SHALL register alu_a/alu_b/alu_s/alu_srot from cmd_a/cmd_b/cmd_op/cmd_rot, load settle counter with SETTLE_CYCLES, and go to ISSUE.
REQ-014 In ISSUE, SHALL decrement the counter each cycle and move to CAPTURE when the counter reaches 1; alu_* outputs SHALL NOT change outside acceptance.
REQ-015 In CAPTURE, SHALL register rsp_y=alu_y, rsp_flags={alu_y2,alu_cout,alu_bout}, rsp_op=alu_s, set rsp_valid=1, and go to RESP.
REQ-016 Latency: with SETTLE_CYCLES=N, rsp_valid SHALL rise N+1 cycles after the accepting edge.
REQ-017 In RESP, rsp_valid and all rsp_* fields SHALL hold stable until rsp_valid and rsp_ready are both 1 on an edge; then rsp_valid SHALL clear, rsp_tag SHALL increment, and the state SHALL return to IDLE.
REQ-018 rsp_tag SHALL wrap from 15 to 0.
REQ-019 rsp_ready asserted before RESP SHALL have no effect; cmd_valid outside IDLE SHALL be ignored and the command not consumed.
REQ-020 All op codes 000..111 SHALL be accepted; ALU outputs are passed through without interpretation (op 111 returns the ALU's zero result).
REQ-021 Minimum command-to-command spacing SHALL be SETTLE_CYCLES+3 cycles when rsp_ready is held at 1.

Reset
REQ-022 When rst_n=0 at an edge, SHALL force IDLE, and set cmd_ready=0 during reset and 1 on the first cycle after release.
REQ-023 Reset SHALL set alu_a, alu_b, alu_s, alu_srot, rsp_y, rsp_flags, rsp_op, rsp_tag, rsp_valid, and busy to 0.
REQ-024 Reset in ISSUE, CAPTURE, or RESP SHALL abandon the transaction; no rsp_valid pulse SHALL occur for it.

Configuration
REQ-025 Macro ALU_SEQ_ACCUM_EN: when defined, a 4-bit accumulator (reset 0) SHALL load rsp_y at each CAPTURE; an accepted command with cmd_acc=1 SHALL drive alu_a from the accumulator instead of cmd_a.
REQ-026 When ALU_SEQ_ACCUM_EN is undefined, cmd_acc SHALL be ignored, alu_a SHALL always come from cmd_a, and no accumulator SHALL exist.

Verification (bench pairs the block with the four-bit ALU, SETTLE_CYCLES=1)
REQ-027 Sequence A=1100, B=0011, op=001, rsp_ready=1 -> rsp_valid rises 2 cycles after accept with rsp_y=1111, rsp_flags=100, and rsp_tag=0.
REQ-028 Sequence A=1111, B=0001, op=001 -> rsp_y=0000 and rsp_flags=110; then A=1100, B=0011, op=010 -> rsp_y=1001, rsp_flags=100, and rsp_tag=1.
REQ-029 Op=000 with rsp_ready held at 0 for 5 cycles -> rsp_valid=1, rsp_y=0000, and cmd_ready=0 throughout; a command offered meanwhile is not accepted until one cycle after the rsp handshake.
REQ-030 16 back-to-back commands -> rsp_tag runs 0..15, and the 17th response carries tag 0.
REQ-031 rst_n=0 pulsed in ISSUE -> no rsp_valid; all outputs are 0 and cmd_ready=1 the cycle after release.
REQ-032 With ALU_SEQ_ACCUM_EN defined, op=001 A=0011 B=0001 (result 0100), then op=001 cmd_acc=1 B=0010 -> alu_a=0100 and rsp_y=0110.
